alu_arbiter: RTL and testbench

Shares the single combinational ALU between two requesters, e.g. the core execute path (port 0) and the debug/command path (port 1). Uses valid/ready handshakes on request and response. Round-robin arbitration, one transaction in flight. Operands are latched, the ALU result is captured into a register, and the result is held until the owner accepts it.

---
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the single shared combinational ALU.
// One transaction is in flight at a time. Operands are latched on accept,
// the ALU result is registered, and it is held until the owner takes it.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no transaction; grant one valid requester (round-robin)
//   EXEC  | latched operands drive the ALU; result captured at cycle end
//   RESP  | rsp{owner}_valid high with the held result until rsp_ready
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int RES_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [RES_W-1:0]  rsp0_result,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp1_result,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [RES_W-1:0]  alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [RES_W-1:0]    result_q, result_d;

  logic                any_valid;
  logic                grant;

  // Round-robin pick: the port that did not win last time takes a tie.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Next-state, register updates and handshake outputs; ena=0 freezes everything.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ena && any_valid) begin
          // The granted port is always valid, so ready implies acceptance.
          req0_ready = ~grant;
          req1_ready = grant;
          owner_d    = grant;
          a_d        = grant ? req1_a  : req0_a;
          b_d        = grant ? req1_b  : req0_b;
          op_d       = grant ? req1_op : req0_op;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (ena) begin
          result_d = alu_result;
          state_d  = RESP;
        end
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (ena && (owner_q ? rsp1_ready : rsp0_ready)) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so port 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
    end
  end

  // ALU is fed only from the latched operands; results leave from the held register.
  always_comb begin
    alu_a       = a_q;
    alu_b       = b_q;
    alu_opcode  = op_q;
    rsp0_result = result_q;
    rsp1_result = result_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small combinational ALU model.
module tb_alu_arbiter;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int RES_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic              req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [OP_W-1:0]   req0_op, req1_op, alu_opcode;
  logic [RES_W-1:0]  rsp0_result, rsp1_result, alu_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // ALU model: add, sub, mul, div (x/0 -> 0), and, or, xor, less-than.
  always_comb begin
    case (alu_opcode)
      3'd0: alu_result = {8'd0, alu_a} + {8'd0, alu_b};
      3'd1: alu_result = {8'd0, alu_a} - {8'd0, alu_b};
      3'd2: alu_result = {8'd0, alu_a} * {8'd0, alu_b};
      3'd3: alu_result = (alu_b == 8'd0) ? 16'd0 : {8'd0, alu_a / alu_b};
      3'd4: alu_result = {8'd0, alu_a & alu_b};
      3'd5: alu_result = {8'd0, alu_a | alu_b};
      3'd6: alu_result = {8'd0, alu_a ^ alu_b};
      default: alu_result = (alu_a < alu_b) ? 16'd1 : 16'd0;
    endcase
  end

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; rsp1_ready = 1'b0;

    // Reset values
    #3;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_opcode, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    do_reset();

    // Single op: 12 + 5 on port 0
    req0_valid = 1'b1; req0_a = 8'd12; req0_b = 8'd5; req0_op = 3'd0;
    #1;
    chk("single_req0_ready", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    step();
    req0_valid = 1'b0; req0_a = 8'd99;
    #1;
    chk("single_exec_rsp0_valid", rsp0_valid, 0);
    chk("single_exec_alu_a", alu_a, 12);
    chk("single_exec_ready", req0_ready, 0);
    step();
    chk("single_rsp0_valid", rsp0_valid, 1);
    chk("single_rsp0_result", rsp0_result, 17);
    chk("single_rsp1_valid", rsp1_valid, 0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    chk("single_done_rsp0_valid", rsp0_valid, 0);
    chk("single_idle_alu_b_hold", alu_b, 5);

    // Simultaneous requests after reset: port 0 first
    do_reset();
    req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd20; req0_op = 3'd2;
    req1_valid = 1'b1; req1_a = 8'd3;  req1_b = 8'd7;  req1_op = 3'd1;
    #1;
    chk("sim_req0_ready", req0_ready, 1);
    chk("sim_req1_ready", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("sim_exec_req1_ready", req1_ready, 0);
    step();
    chk("sim_rsp0_valid", rsp0_valid, 1);
    chk("sim_rsp0_result", rsp0_result, 200);
    chk("sim_resp_req1_ready", req1_ready, 0);
    chk("sim_rsp1_valid", rsp1_valid, 0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    #1;
    chk("sim_idle_req1_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    chk("sim_rsp1_valid", rsp1_valid, 1);
    chk("sim_rsp1_result", rsp1_result, 16'hFFFC);

    // Back-pressure on port 1 while port 0 waits
    req0_valid = 1'b1; req0_a = 8'd4; req0_b = 8'd6; req0_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp1_result", rsp1_result, 16'hFFFC);
      chk("bp_req0_ready", req0_ready, 0);
      step();
    end
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    #1;
    chk("bp_after_rsp1_valid", rsp1_valid, 0);
    chk("bp_after_req0_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    step();
    chk("bp_rsp0_result", rsp0_result, 10);
    chk("bp_rsp0_valid", rsp0_valid, 1);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;

    // Fairness: both valid, rsp_ready high, six transactions alternate
    do_reset();
    req0_valid = 1'b1; req0_a = 8'd2; req0_b = 8'd3; req0_op = 3'd2;
    req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd4; req1_op = 3'd1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      #1;
      chk("fair_req0_ready", req0_ready, (t % 2 == 0) ? 1 : 0);
      chk("fair_req1_ready", req1_ready, (t % 2 == 1) ? 1 : 0);
      step();
      step();
      if (t % 2 == 0) begin
        chk("fair_rsp0_valid", rsp0_valid, 1);
        chk("fair_rsp0_result", rsp0_result, 6);
      end else begin
        chk("fair_rsp1_valid", rsp1_valid, 1);
        chk("fair_rsp1_result", rsp1_result, 5);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Divide by zero on port 1 passes a zero result through
    req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd0; req1_op = 3'd3;
    #1;
    chk("div0_req1_ready", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    chk("div0_rsp1_valid", rsp1_valid, 1);
    chk("div0_rsp1_result", rsp1_result, 0);
    step();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Port 0 op so that last_grant becomes 0 before the reset test
    req0_valid = 1'b1; req0_a = 8'd7; req0_b = 8'd2; req0_op = 3'd0;
    step();
    req0_valid = 1'b0;
    step();
    chk("pre_rst_rsp0_result", rsp0_result, 9);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;

    // Reset during EXEC discards the transaction
    req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd5; req1_op = 3'd2;
    step();
    req1_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req0_ready", req0_ready, 0);
    chk("mid_rst_rsp1_valid", rsp1_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_rsp1_valid", rsp1_valid, 0);
      chk("post_rst_rsp0_valid", rsp0_valid, 0);
    end
    req0_valid = 1'b1; req0_a = 8'd12; req0_b = 8'd5; req0_op = 3'd0;
    req1_valid = 1'b1; req1_a = 8'd1;  req1_b = 8'd1; req1_op = 3'd0;
    #1;
    chk("post_rst_req0_ready", req0_ready, 1);
    chk("post_rst_req1_ready", req1_ready, 0);

    // ena low for four cycles in RESP freezes the response
    step();
    req0_valid = 1'b0;
    step();
    chk("ena_rsp0_valid", rsp0_valid, 1);
    ena = 1'b0;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ena_frz_rsp0_valid", rsp0_valid, 1);
      chk("ena_frz_rsp0_result", rsp0_result, 17);
      chk("ena_frz_req1_ready", req1_ready, 0);
      chk("ena_frz_alu_a", alu_a, 12);
      step();
    end
    ena = 1'b1;
    #1;
    chk("ena_back_rsp0_valid", rsp0_valid, 1);
    step();
    rsp0_ready = 1'b0;
    #1;
    chk("ena_done_rsp0_valid", rsp0_valid, 0);
    chk("ena_done_req1_ready", req1_ready, 1);
    req1_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
